bcd_stopwatch_ctrl: RTL and testbench
=====================================

# bcd_stopwatch_ctrl

Sequencing controller for the two-digit BCD counter (00–99), built as a start/stop/lap stopwatch. It converts single-cycle user commands into the counter's `En` and `clear` controls through a programmable prescaler. It also owns a lap-hold register for the display path and a sticky overflow flag. It sits between the debounced button logic and the BCD counter; `count_q` is fed back from the counter's `Q`.

## Interface
- `PRESCALE`, default 10: clock cycles per count increment; legal values ≥ 2.
- `clk`, input, 1: single system clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start_stop`, input, 1: one-cycle command pulse that toggles between running and paused.
- `lap`, input, 1: one-cycle command pulse that freezes or releases the display.
- `clr_cmd`, input, 1: one-cycle command pulse that returns the block to zero/idle.
- `count_q`, input, 8: live BCD value from the counter, tens in [7:4] and units in [3:0].
- `cnt_en`, output, 1: registered count enable to the counter's `En`.
- `cnt_clear`, output, 1: registered synchronous clear to the counter's `clear`.
- `disp`, output, 8: BCD value to display.
- `running`, output, 1: high in RUN or LAP.
- `ovf`, output, 1: sticky flag, set when the counter wraps from 99 to 00.

## Operation
- States are IDLE, RUN, PAUSE and LAP.
- Command priority each cycle: `clr_cmd` > `start_stop` > `lap`. A lower-priority command in the same cycle is dropped.
- `clr_cmd` in any state:
  - next state is IDLE;
  - `cnt_clear` is high for exactly the next cycle;
  - prescaler goes to 0, `ovf` goes to 0, lap-hold goes to 8'h00.
- IDLE:
  - `start_stop` moves to RUN with the prescaler at 0;
  - `lap` is ignored.
- RUN:
  - `start_stop` moves to PAUSE;
  - `lap` latches `count_q` into lap-hold and moves to LAP.
- LAP:
  - the counter keeps running;
  - `lap` moves to RUN;
  - `start_stop` moves to PAUSE and releases the display.
- PAUSE:
  - `start_stop` moves to RUN, and the prescaler resumes from its retained value with no tick lost or duplicated;
  - `lap` is ignored.
- Prescaler behaviour:
  - increments only in RUN and LAP;
  - when its value is PRESCALE−1 it wraps to 0 and `cnt_en` is registered high for the following cycle;
  - `cnt_en` is otherwise 0, and is never high in IDLE or PAUSE.
- A `start_stop` that leaves RUN or LAP in the same cycle as a wrap still issues that tick's `cnt_en`.
- Overflow: in any cycle with `cnt_en`=1 and `count_q`=8'h99, `ovf` is set at the next edge. It stays set until `clr_cmd` or reset.
- Display: `disp` = lap-hold in LAP, otherwise `count_q` (combinational mux).
- Width rule: prescaler width is $clog2(PRESCALE). No arithmetic is done on BCD values; 8'h99 is compared directly.

## Timing
- Reset values:
  - state IDLE;
  - prescaler 0, `cnt_en` 0, `ovf` 0, lap-hold 8'h00;
  - `cnt_clear` 1, so the counter is zeroed on the first edge after `rst_n` rises;
  - `running` 0.
- `cnt_clear` drops to 0 one cycle after reset release.
- Reset mid-run aborts immediately with no further `cnt_en`.
- The first `cnt_en` pulse is PRESCALE cycles after the edge that samples `start_stop`. `count_q` then changes one edge later.
- Steady state in RUN: exactly one `cnt_en` every PRESCALE cycles.
- Command-to-state latency is 1 cycle. `running` and `disp` follow state with no extra delay.
- Commands are sampled every edge; pulses longer than one cycle are treated as repeated commands, and the upstream logic must guarantee single-cycle pulses.

## Structure
- Package `bcd_sw_pkg` holds:
  - `typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_PAUSE, SW_LAP} sw_state_t`;
  - `localparam logic [7:0] BCD_MAX = 8'h99`.
- Sub-module `bcd_sw_prescaler` holds the modulo-PRESCALE counter. It has inputs `clk`, `rst_n`, `run`, `zero` and output `tick` (registered).
- Top level holds the FSM, lap-hold register, `ovf` register and display mux.

## Test plan
All scenarios use PRESCALE=4 with a behavioural BCD counter in the loop.
1. Reset release:
   - `cnt_clear`=1 for the first cycle, then 0;
   - `disp`=8'h00, `running`=0, `cnt_en`=0 for 20 idle cycles.
2. `start_stop`, then 40 cycles:
   - `cnt_en` pulses at cycles 4, 8, …, 40;
   - `count_q` reaches 8'h10.
3. Pause/resume timing:
   - pause at prescaler value 2 for 10 cycles, then resume;
   - next `cnt_en` arrives 2 cycles after resume, with no extra pulse.
4. Lap:
   - at `count_q`=8'h23, `lap` holds `disp` at 8'h23 while `count_q` advances to 8'h27;
   - second `lap` restores `disp`=`count_q`.
5. Wrap:
   - run from 8'h99;
   - the tick gives `count_q`=8'h00 and `ovf`=1;
   - `ovf` stays set across pause and resume.
6. Simultaneous commands:
   - `clr_cmd`+`start_stop` in RUN gives IDLE, `cnt_clear` for 1 cycle, `ovf`=0;
   - `start_stop`+`lap` in RUN gives PAUSE with lap-hold unchanged;
   - `rst_n` low mid-RUN gives immediate IDLE outputs.

Source files
------------

// File: rtl/bcd_sw_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_sw_pkg;

  typedef enum logic [1:0] {
    SW_IDLE,
    SW_RUN,
    SW_PAUSE,
    SW_LAP
  } sw_state_t;

  // Top of the two-digit BCD range; compared directly, never computed.
  localparam logic [7:0] BCD_MAX = 8'h99;

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command/status bundle between the button logic, the controller and the BCD counter.
interface bcd_stopwatch_ctrl_if;

  logic       start_stop;
  logic       lap;
  logic       clr_cmd;
  logic [7:0] count_q;
  logic       cnt_en;
  logic       cnt_clear;
  logic [7:0] disp;
  logic       running;
  logic       ovf;

  // Environment side: issues commands, returns the counter value, consumes controls.
  modport master (
    output start_stop, lap, clr_cmd, count_q,
    input  cnt_en, cnt_clear, disp, running, ovf
  );

  // Controller side.
  modport slave (
    input  start_stop, lap, clr_cmd, count_q,
    output cnt_en, cnt_clear, disp, running, ovf
  );

endinterface

// File: rtl/bcd_sw_prescaler.sv
// Modulo-PRESCALE cycle counter producing a registered one-cycle tick on wrap.
// PRESCALE must be at least 2.
module bcd_sw_prescaler #(
  parameter int PRESCALE = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic zero,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] count;

  // Count while running, hold while stopped; zero wins over run so a clear never ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (zero) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (run) begin
      if (count == LAST) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + W'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/lap sequencing for a two-digit BCD counter: FSM, lap-hold,
// sticky overflow and display mux around a cycle prescaler.
module bcd_stopwatch_ctrl
  import bcd_sw_pkg::*;
#(
  parameter int PRESCALE = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  bcd_stopwatch_ctrl_if.slave bus
);

  sw_state_t  state;
  logic [7:0] lap_hold;
  logic       cnt_clear_q;
  logic       ovf_q;
  logic       tick;
  logic       active;
  logic       zero;

  // The prescaler advances on the current state, so a stop command in the
  // wrap cycle still lets that tick through and a resume loses nothing.
  assign active = (state == SW_RUN) || (state == SW_LAP);
  assign zero   = bus.clr_cmd || ((state == SW_IDLE) && bus.start_stop);

  bcd_sw_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (active),
    .zero (zero),
    .tick (tick)
  );

  // State, counter clear, overflow and lap-hold; clr_cmd > start_stop > lap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SW_IDLE;
      cnt_clear_q <= 1'b1;
      ovf_q       <= 1'b0;
      lap_hold    <= 8'h00;
    end else begin
      cnt_clear_q <= bus.clr_cmd;
      if (bus.clr_cmd) begin
        state    <= SW_IDLE;
        ovf_q    <= 1'b0;
        lap_hold <= 8'h00;
      end else begin
        if (tick && (bus.count_q == BCD_MAX)) begin
          ovf_q <= 1'b1;
        end
        case (state)
          SW_IDLE: begin
            if (bus.start_stop) state <= SW_RUN;
          end
          SW_RUN: begin
            if (bus.start_stop) begin
              state <= SW_PAUSE;
            end else if (bus.lap) begin
              lap_hold <= bus.count_q;
              state    <= SW_LAP;
            end
          end
          SW_LAP: begin
            if (bus.start_stop) state <= SW_PAUSE;
            else if (bus.lap)   state <= SW_RUN;
          end
          SW_PAUSE: begin
            if (bus.start_stop) state <= SW_RUN;
          end
          default: state <= SW_IDLE;
        endcase
      end
    end
  end

  assign bus.cnt_en    = tick;
  assign bus.cnt_clear = cnt_clear_q;
  assign bus.ovf       = ovf_q;
  assign bus.running   = active;
  assign bus.disp      = (state == SW_LAP) ? lap_hold : bus.count_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl with PRESCALE=4 and a behavioural BCD counter in the loop.
module tb_bcd_stopwatch_ctrl;

  localparam int PRESCALE = 4;

  logic clk;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  bcd_stopwatch_ctrl_if bus ();

  bcd_stopwatch_ctrl #(
    .PRESCALE(PRESCALE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-digit BCD increment done in plain decimal arithmetic.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    int d;
    logic [3:0] tens;
    logic [3:0] units;
    d     = (int'(v[7:4]) * 10 + int'(v[3:0]) + 1) % 100;
    tens  = 4'(d / 10);
    units = 4'(d % 10);
    return {tens, units};
  endfunction

  // Behavioural BCD counter: clear beats enable.
  initial bus.count_q = 8'h37;
  always @(posedge clk) begin
    if (bus.cnt_clear)   bus.count_q <= 8'h00;
    else if (bus.cnt_en) bus.count_q <= bcd_inc(bus.count_q);
  end

  // Reference model: tracks mode, total active cycles since start, and the
  // outputs those imply.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
  int         m_mode;
  int         m_active;
  logic       m_en;
  logic       m_clear;
  logic       m_ovf;
  logic [7:0] m_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode   <= M_IDLE;
      m_active <= 0;
      m_en     <= 1'b0;
      m_clear  <= 1'b1;
      m_ovf    <= 1'b0;
      m_hold   <= 8'h00;
    end else begin
      m_clear <= bus.clr_cmd;
      if (bus.clr_cmd) begin
        m_mode   <= M_IDLE;
        m_active <= 0;
        m_en     <= 1'b0;
        m_ovf    <= 1'b0;
        m_hold   <= 8'h00;
      end else begin
        if (m_en && bus.count_q == 8'h99) m_ovf <= 1'b1;
        if (m_mode == M_RUN || m_mode == M_LAP) begin
          m_active <= m_active + 1;
          m_en     <= ((m_active + 1) % PRESCALE) == 0;
        end else begin
          m_en <= 1'b0;
        end
        if (m_mode == M_IDLE && bus.start_stop) begin
          m_mode   <= M_RUN;
          m_active <= 0;
        end else if (m_mode == M_RUN) begin
          if (bus.start_stop) m_mode <= M_PAUSE;
          else if (bus.lap) begin
            m_mode <= M_LAP;
            m_hold <= bus.count_q;
          end
        end else if (m_mode == M_LAP) begin
          if (bus.start_stop) m_mode <= M_PAUSE;
          else if (bus.lap)   m_mode <= M_RUN;
        end else if (m_mode == M_PAUSE && bus.start_stop) begin
          m_mode <= M_RUN;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, compare all outputs against the model.
  always begin
    @(posedge clk);
    #1;
    checkOutput("model cnt_en", {7'd0, bus.cnt_en}, {7'd0, m_en});
    checkOutput("model cnt_clear", {7'd0, bus.cnt_clear}, {7'd0, m_clear});
    checkOutput("model running", {7'd0, bus.running}, {7'd0, (m_mode == M_RUN || m_mode == M_LAP)});
    checkOutput("model ovf", {7'd0, bus.ovf}, {7'd0, m_ovf});
    checkOutput("model disp", bus.disp, (m_mode == M_LAP) ? m_hold : bus.count_q);
  end

  // Drive one command pulse: set on a falling edge, drop just after the sampling edge.
  task automatic applyStimulus(input logic ss, input logic lp, input logic clr);
    @(negedge clk);
    bus.start_stop = ss;
    bus.lap        = lp;
    bus.clr_cmd    = clr;
    @(posedge clk);
    #1;
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clr_cmd    = 1'b0;
  endtask

  task automatic waitCount(input logic [7:0] value, input int limit, input string name);
    bit found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (bus.count_q == value) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: timeout, count_q=%02h, required %02h", name, bus.count_q, value);
    end
  endtask

  task automatic waitEnable(input int limit, input string name);
    bit found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (bus.cnt_en) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: timeout, cnt_en=%0b, required 1", name, bus.cnt_en);
    end
  endtask

  initial begin
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clr_cmd    = 1'b0;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset release: clear held for the first edge, then idle quiet.
    rst_n = 1'b1;
    #1;
    checkOutput("reset cnt_clear high", {7'd0, bus.cnt_clear}, 8'h01);
    checkOutput("reset running", {7'd0, bus.running}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("cnt_clear drops", {7'd0, bus.cnt_clear}, 8'h00);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      checkOutput("idle disp", bus.disp, 8'h00);
      checkOutput("idle running", {7'd0, bus.running}, 8'h00);
      checkOutput("idle cnt_en", {7'd0, bus.cnt_en}, 8'h00);
    end

    // Start and count for 40 cycles: a pulse on every fourth.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start running", {7'd0, bus.running}, 8'h01);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      checkOutput("run cnt_en phase", {7'd0, bus.cnt_en}, {7'd0, (k % 4) == 0});
    end
    @(posedge clk);
    #1;
    checkOutput("run count 10", bus.count_q, 8'h10);

    // Pause with prescaler retained at 2, hold 10 cycles, resume.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput("pause cnt_en", {7'd0, bus.cnt_en}, 8'h00);
      checkOutput("pause running", {7'd0, bus.running}, 8'h00);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      checkOutput("resume cnt_en", {7'd0, bus.cnt_en}, {7'd0, (k == 2 || k == 6)});
    end

    // Lap at 23: display freezes while the counter moves on to 27, then releases.
    waitCount(8'h23, 200, "wait 23");
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lap disp held", bus.disp, 8'h23);
    checkOutput("lap running", {7'd0, bus.running}, 8'h01);
    waitCount(8'h27, 100, "wait 27");
    checkOutput("lap disp still held", bus.disp, 8'h23);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lap release disp", bus.disp, 8'h27);

    // Clear, then run up through 99 and wrap.
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr cnt_clear", {7'd0, bus.cnt_clear}, 8'h01);
    checkOutput("clr running", {7'd0, bus.running}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("clr cnt_clear one cycle", {7'd0, bus.cnt_clear}, 8'h00);
    checkOutput("clr count zero", bus.count_q, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCount(8'h99, 600, "wait 99");
    checkOutput("ovf before wrap", {7'd0, bus.ovf}, 8'h00);
    waitCount(8'h00, 10, "wait wrap");
    checkOutput("ovf after wrap", {7'd0, bus.ovf}, 8'h01);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("ovf held in pause", {7'd0, bus.ovf}, 8'h01);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ovf held after resume", {7'd0, bus.ovf}, 8'h01);

    // clr_cmd together with start_stop in RUN: clear wins.
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("clr+ss running", {7'd0, bus.running}, 8'h00);
    checkOutput("clr+ss cnt_clear", {7'd0, bus.cnt_clear}, 8'h01);
    checkOutput("clr+ss ovf", {7'd0, bus.ovf}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("clr+ss clear drops", {7'd0, bus.cnt_clear}, 8'h00);

    // Set a lap value, then start_stop together with lap in RUN: pause, hold unchanged.
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCount(8'h02, 40, "wait 02");
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCount(8'h04, 40, "wait 04");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ss+lap running", {7'd0, bus.running}, 8'h00);
    checkOutput("ss+lap disp", bus.disp, 8'h04);
    checkOutput("ss+lap hold kept", dut.lap_hold, 8'h02);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume running", {7'd0, bus.running}, 8'h01);

    // Asynchronous reset right while an enable pulse is out.
    waitEnable(20, "wait cnt_en");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst cnt_en", {7'd0, bus.cnt_en}, 8'h00);
    checkOutput("async rst running", {7'd0, bus.running}, 8'h00);
    checkOutput("async rst cnt_clear", {7'd0, bus.cnt_clear}, 8'h01);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("post rst idle disp", bus.disp, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
